// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM host-interface arbiter.
// Arbiter FSM state encoding plus the host data width.
package sdram_pkg;

    localparam int unsigned SDRAM_DATA_WIDTH = 16;

    localparam logic [2:0] ARB_IDLE      = 3'd0;
    localparam logic [2:0] ARB_ISSUE     = 3'd1;
    localparam logic [2:0] ARB_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ARB_WAIT_DONE = 3'd3;
    localparam logic [2:0] ARB_ACK       = 3'd4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant picker for the SDRAM arbiter.
// Default build: round robin, the port that did not win last time takes a tie.
// Build option SDRAM_ARB_FIXED_PRIO_EN: strict priority, port 0 always wins a tie.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Port 1 only wins when port 0 is not asking.
    always_comb begin
        grant = ~req[0];
    end
`else
    // On a tie the non-owner wins; otherwise the lone requester wins.
    always_comb begin
        if (req == 2'b11) begin
            grant = ~last_owner;
        end else begin
            grant = req[1];
        end
    end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of one SDRAM controller host interface.
// Serialises single-word reads/writes, waits out the controller busy pulse,
// captures read data and returns a one-cycle ack to the granted port.
// Build option SDRAM_ARB_FIXED_PRIO_EN selects strict port-0 priority (see arb_rr2).
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned HADDR_WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0,
    input  logic                        req1,
    input  logic                        we0,
    input  logic                        we1,
    input  logic [HADDR_WIDTH-1:0]      addr0,
    input  logic [HADDR_WIDTH-1:0]      addr1,
    input  logic [SDRAM_DATA_WIDTH-1:0] wdata0,
    input  logic [SDRAM_DATA_WIDTH-1:0] wdata1,
    output logic                        ack0,
    output logic                        ack1,
    output logic [SDRAM_DATA_WIDTH-1:0] rdata0,
    output logic [SDRAM_DATA_WIDTH-1:0] rdata1,
    output logic [HADDR_WIDTH-1:0]      haddr,
    output logic [SDRAM_DATA_WIDTH-1:0] data_input,
    input  logic [SDRAM_DATA_WIDTH-1:0] data_output,
    input  logic                        busy,
    output logic                        rd_enable,
    output logic                        wr_enable,
    output logic                        owner
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       we_q;
    logic       grant;
    logic       start;
    logic       grant_we;

    arb_rr2 u_pick (
        .req        ({req1, req0}),
        .last_owner (owner),
        .grant      (grant)
    );

    // A new transaction starts only from IDLE with the controller quiet.
    always_comb begin
        start    = (state_q == ARB_IDLE) && (req0 || req1) && !busy;
        grant_we = grant ? we1 : we0;
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:      if ((req0 || req1) && !busy) state_d = ARB_ISSUE;
            ARB_ISSUE:     state_d = ARB_WAIT_BUSY;
            ARB_WAIT_BUSY: if (busy) state_d = ARB_WAIT_DONE;
            ARB_WAIT_DONE: if (!busy) state_d = ARB_ACK;
            ARB_ACK:       state_d = ARB_IDLE;
            default:       state_d = ARB_IDLE;
        endcase
    end

    // State, host-side fields, strobes, acks and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            we_q       <= 1'b0;
            owner      <= 1'b1;
            haddr      <= '0;
            data_input <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            rd_enable  <= 1'b0;
            wr_enable  <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Strobes and acks are single-cycle pulses by default.
            rd_enable <= 1'b0;
            wr_enable <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (start) begin
                        owner      <= grant;
                        we_q       <= grant_we;
                        haddr      <= grant ? addr1 : addr0;
                        data_input <= grant ? wdata1 : wdata0;
                        // Registered so the strobe is high exactly during ISSUE.
                        rd_enable  <= ~grant_we;
                        wr_enable  <= grant_we;
                    end
                end
                ARB_WAIT_DONE: begin
                    if (!busy) begin
                        if (!we_q) begin
                            if (owner) begin
                                rdata1 <= data_output;
                            end else begin
                                rdata0 <= data_output;
                            end
                        end
                        ack0 <= ~owner;
                        ack1 <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: requester drivers feed a scoreboard,
// a negedge monitor checks grants, host fields, strobes, acks and read data.
module tb_sdram_arbiter;

    localparam int AW = 24;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req = '0;
    logic [1:0]      we = '0;
    logic [AW-1:0]   addr [2];
    logic [15:0]     wdata [2];
    logic            ack0, ack1;
    logic [15:0]     rdata0, rdata1;
    logic [AW-1:0]   haddr;
    logic [15:0]     data_input, data_output;
    logic            busy, rd_enable, wr_enable, owner;

    always #5 clk = ~clk;

    sdram_arbiter #(.HADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req[0]),
        .req1        (req[1]),
        .we0         (we[0]),
        .we1         (we[1]),
        .addr0       (addr[0]),
        .addr1       (addr[1]),
        .wdata0      (wdata[0]),
        .wdata1      (wdata[1]),
        .ack0        (ack0),
        .ack1        (ack1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .haddr       (haddr),
        .data_input  (data_input),
        .data_output (data_output),
        .busy        (busy),
        .rd_enable   (rd_enable),
        .wr_enable   (wr_enable),
        .owner       (owner)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller model: busy rises the cycle after a strobe and stays high 8 cycles.
    int unsigned busy_cnt = 0;
    logic        busy_force = 1'b0;
    logic [15:0] mem_addr = '0;
    always @(posedge clk) begin
        if (rd_enable || wr_enable) begin
            busy_cnt <= 8;
            mem_addr <= haddr[15:0];
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign busy = busy_force || (busy_cnt != 0);
    assign data_output = mem_addr ^ 16'hA5A5;

    // Requester drivers: pop queued transactions, hold req until ack, drop it next cycle.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    txn_t cur [2];
    bit [1:0] active = '0;
    bit [1:0] dropping = '0;
    int gap [2] = '{0, 0};
    int done [2] = '{0, 0};
    int gap_max = 0;
    bit hold = 1'b1;

    always @(posedge clk) begin
        txn_t t;
        #1;
        if (!hold) begin
            if (!rst_n) begin
                req = '0;
                active = '0;
                dropping = '0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (dropping[p]) begin
                        req[p] = 1'b0;
                        dropping[p] = 1'b0;
                        active[p] = 1'b0;
                        done[p]++;
                        gap[p] = $urandom_range(gap_max, 0);
                    end else if (active[p]) begin
                        if ((p == 0 && ack0) || (p == 1 && ack1)) dropping[p] = 1'b1;
                    end else if (gap[p] > 0) begin
                        gap[p]--;
                    end else if ((p == 0) ? (q0.size() != 0) : (q1.size() != 0)) begin
                        if (p == 0) t = q0.pop_front();
                        else t = q1.pop_front();
                        cur[p] = t;
                        we[p] = t.we;
                        addr[p] = t.addr;
                        wdata[p] = t.wdata;
                        req[p] = 1'b1;
                        active[p] = 1'b1;
                    end
                end
            end
        end
    end

    // Scoreboard and monitor.
    typedef struct {
        int          port;
        bit          rd;
        logic [15:0] exp;
    } exp_t;

    exp_t        ackq[$];
    int          grant_log[$];
    int          ack_count [2] = '{0, 0};
    bit          model_owner = 1'b1;
    logic [15:0] mrd [2] = '{16'h0, 16'h0};
    logic [1:0]  prev_req = '0;
    bit          prev_busy = 1'b0;
    int          low_run = 0;
    bit          inflight = 1'b0;
    logic [AW-1:0] exp_haddr = '0;
    logic [15:0] exp_din = '0;
    logic        rst_smp = 1'b0;

    always @(posedge clk) rst_smp <= rst_n;

    // Which port the arbitration rules say wins, given the requests seen in IDLE.
    function automatic int expected_grant(input logic [1:0] r, input bit last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last == 1'b0) ? 1 : 0;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   g;
        if (busy) low_run = 0;
        else low_run++;
        if (!rst_smp) begin
            check((rd_enable | wr_enable) == 1'b0, "reset_strobe", {rd_enable, wr_enable}, 0);
            check({ack1, ack0} == 2'b00, "reset_ack", {ack1, ack0}, 0);
            check(owner == 1'b1, "reset_owner", owner, 1);
            check(haddr == '0, "reset_haddr", haddr, 0);
            ackq.delete();
            model_owner = 1'b1;
            mrd[0] = '0;
            mrd[1] = '0;
            inflight = 1'b0;
        end else begin
            if (rd_enable || wr_enable) begin
                check(!(rd_enable && wr_enable), "one_strobe", {rd_enable, wr_enable}, 1);
                check(prev_req != 2'b00, "strobe_without_req", prev_req, 1);
                check(!prev_busy, "grant_while_busy", prev_busy, 0);
                check(!inflight, "double_issue", inflight, 0);
                g = expected_grant(prev_req, model_owner);
                check(owner == g[0], "grant_owner", owner, g);
                check(haddr == cur[g].addr, "haddr", haddr, cur[g].addr);
                check(data_input == cur[g].wdata, "data_input", data_input, cur[g].wdata);
                check(wr_enable == cur[g].we, "strobe_type", wr_enable, cur[g].we);
                model_owner = g[0];
                inflight = 1'b1;
                exp_haddr = cur[g].addr;
                exp_din = cur[g].wdata;
                e.port = g;
                e.rd = !cur[g].we;
                e.exp = cur[g].addr[15:0] ^ 16'hA5A5;
                ackq.push_back(e);
                grant_log.push_back(g);
            end else if (inflight) begin
                check(haddr == exp_haddr, "haddr_stable", haddr, exp_haddr);
                check(data_input == exp_din, "data_input_stable", data_input, exp_din);
            end
            if (ack0 || ack1) begin
                check(ackq.size() != 0, "unexpected_ack", {ack1, ack0}, 0);
                if (ackq.size() != 0) begin
                    e = ackq.pop_front();
                    check({ack1, ack0} == (2'b01 << e.port), "ack_port", {ack1, ack0},
                          2'b01 << e.port);
                    check(low_run == 2, "ack_latency", low_run, 2);
                    if (e.rd) mrd[e.port] = e.exp;
                    check(rdata0 == mrd[0], "rdata0", rdata0, mrd[0]);
                    check(rdata1 == mrd[1], "rdata1", rdata1, mrd[1]);
                    inflight = 1'b0;
                    ack_count[e.port]++;
                end
            end
        end
        prev_req = req;
        prev_busy = busy;
    end

    task automatic wait_done(input int p, input int target, input int budget);
        int n = 0;
        while (done[p] < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(done[p] >= target, (p == 0) ? "timeout_port0" : "timeout_port1", done[p], target);
    endtask

    int   base;
    int   a0_before;
    int   a1_before;
    int   n0;
    int   n1;
    int   exp4 [4] = '{0, 1, 0, 1};
    txn_t t;

    initial begin
        // 1. Reset held 3 cycles with req0 high.
        addr[0] = 24'h000777;
        addr[1] = '0;
        wdata[0] = 16'h1234;
        wdata[1] = '0;
        req = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = '0;
        hold = 1'b0;

        // 2. Port 0 write.
        q0.push_back('{we: 1'b1, addr: 24'h000123, wdata: 16'hBEEF});
        wait_done(0, 1, 200);

        // 3. Port 1 read.
        q1.push_back('{we: 1'b0, addr: 24'h00F0F0, wdata: 16'h0000});
        wait_done(1, 1, 200);
        check(rdata1 == 16'h5555, "t3_rdata1", rdata1, 16'h5555);
        check(rdata0 == 16'h0000, "t3_rdata0_unchanged", rdata0, 0);

        // 4. Both ports requesting continuously.
        base = grant_log.size();
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{we: 1'b1, addr: 24'h000100 + i, wdata: 16'hC000 + i});
            q1.push_back('{we: 1'b0, addr: 24'h000200 + i, wdata: 16'hD000 + i});
        end
        wait_done(0, 3, 400);
        wait_done(1, 3, 400);
        check(grant_log.size() >= base + 4, "t4_grant_count", grant_log.size() - base, 4);
        if (grant_log.size() >= base + 4) begin
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            for (int i = 0; i < 4; i++) begin
                check(grant_log[base + i] == exp4[i], "t4_rr_order", grant_log[base + i], exp4[i]);
            end
`else
            check(grant_log[base] == 0, "t4_prio_first", grant_log[base], 0);
`endif
        end

        // 5. Busy forced high while idle: no strobe until it falls.
        @(posedge clk);
        #1;
        busy_force = 1'b1;
        q0.push_back('{we: 1'b0, addr: 24'h00ABCD, wdata: 16'h0F0F});
        repeat (6) begin
            @(negedge clk);
            check(!(rd_enable || wr_enable), "t5_no_strobe_busy", {rd_enable, wr_enable}, 0);
        end
        @(posedge clk);
        #1;
        busy_force = 1'b0;
        @(negedge clk);
        check(!(rd_enable || wr_enable), "t5_no_strobe_release", {rd_enable, wr_enable}, 0);
        @(negedge clk);
        check(rd_enable, "t5_strobe_after_release", rd_enable, 1);
        wait_done(0, 4, 200);

        // 6. Reset during WAIT_DONE abandons the transaction.
        a0_before = ack_count[0];
        q0.push_back('{we: 1'b0, addr: 24'h003333, wdata: 16'h0000});
        n0 = 0;
        while (!(busy && active[0]) && n0 < 100) begin
            @(posedge clk);
            n0++;
        end
        check(busy && active[0], "t6_reach_wait", busy, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check(ack_count[0] == a0_before, "t6_no_ack0", ack_count[0], a0_before);
        a1_before = ack_count[1];
        q1.push_back('{we: 1'b1, addr: 24'h004444, wdata: 16'h9999});
        wait_done(1, 4, 200);
        repeat (3) @(posedge clk);
        check(ack_count[1] == a1_before + 1, "t6_single_ack1", ack_count[1], a1_before + 1);

        // 7. Randomised traffic on both ports.
        gap_max = 3;
        n0 = done[0];
        n1 = done[1];
        for (int i = 0; i < 40; i++) begin
            t.we = 1'($urandom_range(1, 0));
            t.addr = AW'($urandom);
            t.wdata = 16'($urandom);
            if ($urandom_range(1, 0) == 0) begin
                q0.push_back(t);
                n0++;
            end else begin
                q1.push_back(t);
                n1++;
            end
        end
        wait_done(0, n0, 2000);
        wait_done(1, n1, 2000);
        repeat (5) @(posedge clk);
        check(ackq.size() == 0, "final_scoreboard_empty", ackq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
